// File: rtl/obstacle_scheduler.sv
// rtl/obstacle_scheduler.sv - spawns, retires and reports the two live scrolling obstacles
module obstacle_scheduler #(
    parameter logic [10:0] MIN_GAP   = 11'd160,
    parameter logic [10:0] SPAWN_X   = 11'd640,
    parameter logic [10:0] OBS_WIDTH = 11'd32,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        halt,
    input  logic        game_rst,
    input  logic [10:0] scrolladdr,
    output logic        obs0_valid,
    output logic [10:0] obs0_dx,
    output logic        obs0_type,
    output logic        obs1_valid,
    output logic [10:0] obs1_dx,
    output logic        obs1_type,
    output logic        obstacle_active,
    output logic        spawn_pulse
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RETIRE,
        S_SPAWN,
        S_UPDATE
    } state_t;

    localparam logic signed [11:0] NEG_WIDTH = -$signed({1'b0, OBS_WIDTH});

    state_t      state_q;
    logic [1:0]  count_q;
    logic [10:0] pos0_q, pos1_q;
    logic        type0_q, type1_q;
    logic [15:0] lfsr_q;
    logic [10:0] last_spawn_q;
    logic [10:0] next_gap_q;

    logic        obs0_valid_q, obs1_valid_q;
    logic [10:0] obs0_dx_q, obs1_dx_q;
    logic        obs0_type_q, obs1_type_q;
    logic        active_q;
    logic        spawn_pulse_q;

    logic [10:0] dx0_d, dx1_d;
    logic        retire_d;
    logic [15:0] lfsr_d;
    logic [10:0] spawn_pos_d;
    logic [10:0] dist_d;
    logic        can_spawn_d;

    // Screen offsets wrap mod 2048; the head is retired once fully past the left edge.
    assign dx0_d       = pos0_q - scrolladdr;
    assign dx1_d       = pos1_q - scrolladdr;
    assign retire_d    = (count_q != 2'd0) && ($signed({dx0_d[10], dx0_d}) < NEG_WIDTH);
    assign lfsr_d      = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    assign spawn_pos_d = scrolladdr + SPAWN_X;
    assign dist_d      = spawn_pos_d - last_spawn_q;
    assign can_spawn_d = (dist_d >= next_gap_q) && (count_q != 2'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            count_q       <= 2'd0;
            pos0_q        <= 11'd0;
            pos1_q        <= 11'd0;
            type0_q       <= 1'b0;
            type1_q       <= 1'b0;
            lfsr_q        <= LFSR_SEED;
            last_spawn_q  <= 11'd0;
            next_gap_q    <= MIN_GAP;
            obs0_valid_q  <= 1'b0;
            obs0_dx_q     <= 11'd0;
            obs0_type_q   <= 1'b0;
            obs1_valid_q  <= 1'b0;
            obs1_dx_q     <= 11'd0;
            obs1_type_q   <= 1'b0;
            active_q      <= 1'b0;
            spawn_pulse_q <= 1'b0;
        end else if (game_rst) begin
            // LFSR deliberately survives a restart so successive games differ.
            state_q       <= S_IDLE;
            count_q       <= 2'd0;
            pos0_q        <= 11'd0;
            pos1_q        <= 11'd0;
            type0_q       <= 1'b0;
            type1_q       <= 1'b0;
            last_spawn_q  <= 11'd0;
            next_gap_q    <= MIN_GAP;
            obs0_valid_q  <= 1'b0;
            obs0_dx_q     <= 11'd0;
            obs0_type_q   <= 1'b0;
            obs1_valid_q  <= 1'b0;
            obs1_dx_q     <= 11'd0;
            obs1_type_q   <= 1'b0;
            active_q      <= 1'b0;
            spawn_pulse_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (frame_tick && !halt) begin
                        state_q <= S_RETIRE;
                    end
                end
                S_RETIRE: begin
                    if (retire_d) begin
                        pos0_q  <= pos1_q;
                        type0_q <= type1_q;
                        count_q <= count_q - 2'd1;
                    end
                    lfsr_q  <= lfsr_d;
                    state_q <= S_SPAWN;
                end
                S_SPAWN: begin
                    if (can_spawn_d) begin
                        if (count_q == 2'd0) begin
                            pos0_q  <= spawn_pos_d;
                            type0_q <= lfsr_q[7];
                        end else begin
                            pos1_q  <= spawn_pos_d;
                            type1_q <= lfsr_q[7];
                        end
                        count_q       <= count_q + 2'd1;
                        last_spawn_q  <= spawn_pos_d;
                        next_gap_q    <= MIN_GAP + {4'b0, lfsr_q[6:0]};
                        spawn_pulse_q <= 1'b1;
                    end
                    state_q <= S_UPDATE;
                end
                S_UPDATE: begin
                    obs0_valid_q  <= (count_q != 2'd0);
                    obs0_dx_q     <= (count_q != 2'd0) ? dx0_d : 11'd0;
                    obs0_type_q   <= (count_q != 2'd0) ? type0_q : 1'b0;
                    obs1_valid_q  <= (count_q == 2'd2);
                    obs1_dx_q     <= (count_q == 2'd2) ? dx1_d : 11'd0;
                    obs1_type_q   <= (count_q == 2'd2) ? type1_q : 1'b0;
                    active_q      <= (count_q != 2'd0);
                    spawn_pulse_q <= 1'b0;
                    state_q       <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign obs0_valid      = obs0_valid_q;
    assign obs0_dx         = obs0_dx_q;
    assign obs0_type       = obs0_type_q;
    assign obs1_valid      = obs1_valid_q;
    assign obs1_dx         = obs1_dx_q;
    assign obs1_type       = obs1_type_q;
    assign obstacle_active = active_q;
    assign spawn_pulse     = spawn_pulse_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// tb/tb_obstacle_scheduler.sv - scoreboard bench for obstacle_scheduler against a frame-level model
module tb_obstacle_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_tick;
    logic        halt;
    logic        game_rst;
    logic [10:0] scrolladdr;
    logic        obs0_valid, obs0_type, obs1_valid, obs1_type;
    logic [10:0] obs0_dx, obs1_dx;
    logic        obstacle_active, spawn_pulse;

    obstacle_scheduler dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .frame_tick      (frame_tick),
        .halt            (halt),
        .game_rst        (game_rst),
        .scrolladdr      (scrolladdr),
        .obs0_valid      (obs0_valid),
        .obs0_dx         (obs0_dx),
        .obs0_type       (obs0_type),
        .obs1_valid      (obs1_valid),
        .obs1_dx         (obs1_dx),
        .obs1_type       (obs1_type),
        .obstacle_active (obstacle_active),
        .spawn_pulse     (spawn_pulse)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        bit          spawn;
        bit          v0;
        logic [10:0] dx0;
        bit          t0;
        bit          v1;
        logic [10:0] dx1;
        bit          t1;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Frame-level reference model: list of live obstacles plus spawn bookkeeping.
    int   mpos[$];
    bit   mtype[$];
    int   mlfsr = 'hACE1;
    int   mlast = 0;
    int   mgap  = 160;
    exp_t mout;

    task automatic set_outputs(input int s);
        mout.v0  = (mpos.size() > 0);
        mout.dx0 = mout.v0 ? 11'((mpos[0] - s) & 2047) : 11'd0;
        mout.t0  = mout.v0 ? mtype[0] : 1'b0;
        mout.v1  = (mpos.size() > 1);
        mout.dx1 = mout.v1 ? 11'((mpos[1] - s) & 2047) : 11'd0;
        mout.t1  = mout.v1 ? mtype[1] : 1'b0;
    endtask

    task automatic model_reset();
        mpos.delete();
        mtype.delete();
        mlast = 0;
        mgap  = 160;
        set_outputs(0);
    endtask

    task automatic model_frame(input int s, output bit sp);
        int d;
        sp = 1'b0;
        if (mpos.size() > 0) begin
            d = (mpos[0] - s) & 2047;
            if (d >= 1024) d -= 2048;
            if (d < -32) begin
                void'(mpos.pop_front());
                void'(mtype.pop_front());
            end
        end
        mlfsr = (mlfsr & 1) ? ((mlfsr >> 1) ^ 'hB400) : (mlfsr >> 1);
        if ((((s + 640 - mlast) & 2047) >= mgap) && (mpos.size() < 2)) begin
            mpos.push_back((s + 640) & 2047);
            mtype.push_back(((mlfsr >> 7) & 1) != 0);
            mlast = (s + 640) & 2047;
            mgap  = 160 + (mlfsr & 127);
            sp    = 1'b1;
        end
        set_outputs(s);
    endtask

    task automatic push_exp(input int due, input bit sp);
        exp_t e;
        e       = mout;
        e.due   = due;
        e.spawn = sp;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, req);
        end
    endtask

    // Monitor: checks spawn_pulse the cycle before an expected output, then the outputs.
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0 && sb[0].due == cyc + 1) begin
                chk("spawn_pulse", int'(spawn_pulse), int'(sb[0].spawn));
            end else if (spawn_pulse) begin
                chk("unexpected_spawn_pulse", 1, 0);
            end
            if (sb.size() > 0 && sb[0].due <= cyc) begin
                chk("obs0_valid", int'(obs0_valid), int'(sb[0].v0));
                chk("obs0_dx", int'(obs0_dx), int'(sb[0].dx0));
                chk("obs0_type", int'(obs0_type), int'(sb[0].t0));
                chk("obs1_valid", int'(obs1_valid), int'(sb[0].v1));
                chk("obs1_dx", int'(obs1_dx), int'(sb[0].dx1));
                chk("obs1_type", int'(obs1_type), int'(sb[0].t1));
                chk("obstacle_active", int'(obstacle_active), int'(sb[0].v0 | sb[0].v1));
                void'(sb.pop_front());
            end
        end
    end

    task automatic do_frame(input int s, input bit h, input int hold);
        int c;
        bit sp;
        scrolladdr = 11'(s);
        halt       = h;
        frame_tick = 1'b1;
        c          = cyc;
        sp         = 1'b0;
        if (!h) model_frame(s, sp);
        push_exp(c + 4, sp);
        repeat (1 + hold) @(negedge clk);
        frame_tick = 1'b0;
        halt       = 1'b0;
        repeat (3 - hold) @(negedge clk);
    endtask

    task automatic do_abort(input int s);
        scrolladdr = 11'(s);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        game_rst   = 1'b1;
        model_reset();
        push_exp(cyc + 1, 1'b0);
        @(negedge clk);
        game_rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic idle_check();
        push_exp(cyc + 2, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int s;
        int wait_cnt;
        rst_n      = 1'b0;
        frame_tick = 1'b0;
        halt       = 1'b0;
        game_rst   = 1'b0;
        scrolladdr = 11'd0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle_check();

        // First spawn at scroll 0, then slow scrolling exercises the gap and the full FIFO.
        s = 0;
        do_frame(s, 1'b0, 0);
        for (int i = 0; i < 200; i++) begin
            s += 2;
            do_frame(s, 1'b0, 0);
        end

        for (int i = 0; i < 3; i++) do_frame(s, 1'b1, i);
        do_abort(s);
        idle_check();

        // Retire boundary on a head at world position 0.
        do_frame(1000, 1'b0, 0);
        do_frame(1408, 1'b0, 0);
        do_frame(1700, 1'b0, 0);
        do_frame(32, 1'b0, 0);
        do_frame(33, 1'b0, 0);

        do_abort(33);
        do_frame(2040, 1'b0, 0);

        s = 2040;
        for (int i = 0; i < 300; i++) begin
            s = (s + int'($urandom_range(0, 40))) & 2047;
            if ($urandom_range(0, 49) == 0) begin
                do_abort(s);
            end else begin
                do_frame(s, $urandom_range(0, 7) == 0, int'($urandom_range(0, 2)));
            end
        end

        wait_cnt = 0;
        while (sb.size() > 0 && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
